mem_port_arbiter: RTL and testbench

- Shares one port of the dual-port ECC memory among NUM_REQ requesters using single-beat round-robin arbitration.
- Issues one memory command per cycle at most, with registered outputs.
- Returns read data to the requester that issued the read, tagged through a latency-matched pipeline.
- One instance per memory port; it sits between the requesters and the memory port pins (en/we/addr/din/dout).

---
 rtl/mem_arb_pkg.sv | 30 +++
 rtl/mem_port_arbiter_rr_priority_picker.sv | 30 +++
 rtl/mem_port_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the memory-port arbiter.
package mem_arb_pkg;

    localparam int DEF_NUM_REQ      = 4;
    localparam int DEF_WIDTH        = 8;
    localparam int DEF_ADDR_WIDTH   = 5;
    localparam int DEF_READ_LATENCY = 1;

    // The index type is sized for the largest supported requester count (8),
    // so every legal NUM_REQ fits without retyping the tag pipeline.
    localparam int MAX_NUM_REQ = 8;

    typedef logic [$clog2(MAX_NUM_REQ)-1:0] req_idx_t;

    // One tag pipeline entry: valid marks a read whose data must be returned.
    typedef struct packed {
        logic     valid;
        req_idx_t idx;
    } rd_tag_t;

    // Round-robin successor with wrap from num_req-1 back to 0.
    function automatic req_idx_t next_ptr(input req_idx_t idx, input int num_req);
        req_idx_t one;
        one = 1;
        if (int'(idx) == num_req - 1)
            return '0;
        return idx + one;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_priority_picker.sv
// Combinational round-robin search: first eligible index at or above the
// pointer, wrapping around.
module rr_priority_picker
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ
) (
    input  logic [NUM_REQ-1:0] i_elig,
    input  req_idx_t           i_ptr,
    output req_idx_t           o_idx,
    output logic               o_found
);

    // Scan offsets 0..NUM_REQ-1 from the pointer; the first hit wins.
    always_comb begin
        int c;
        o_idx   = '0;
        o_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            c = int'(i_ptr) + k;
            if (c >= NUM_REQ)
                c = c - NUM_REQ;
            if (!o_found && i_elig[c]) begin
                o_found = 1'b1;
                o_idx   = req_idx_t'(c);
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-beat round-robin arbiter sharing one memory port among NUM_REQ
// requesters, with a latency-matched tag pipeline routing read data back.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ      = DEF_NUM_REQ,
    parameter int WIDTH        = DEF_WIDTH,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int READ_LATENCY = DEF_READ_LATENCY
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [NUM_REQ-1:0]            i_req,
    input  logic [NUM_REQ-1:0]            i_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_addr,
    input  logic [NUM_REQ*WIDTH-1:0]      i_din,
    output logic [NUM_REQ-1:0]            o_gnt,
    output logic [NUM_REQ-1:0]            o_rvalid,
    output logic [WIDTH-1:0]              o_rdata,
    output logic                          o_mem_en,
    output logic                          o_mem_we,
    output logic [ADDR_WIDTH-1:0]         o_mem_addr,
    output logic [WIDTH-1:0]              o_mem_din,
    input  logic [WIDTH-1:0]              i_mem_dout,
    output logic                          o_busy
);

    logic [NUM_REQ-1:0]    r_gnt;
    logic [NUM_REQ-1:0]    r_rvalid;
    logic [WIDTH-1:0]      r_rdata;
    logic                  r_mem_en;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [WIDTH-1:0]      r_mem_din;
    req_idx_t              r_ptr;

    logic [NUM_REQ-1:0]    w_elig;
    logic [NUM_REQ-1:0]    w_win_onehot;
    req_idx_t              w_win;
    logic                  w_found;
    rd_tag_t               w_tag_in;
    rd_tag_t               w_tag_out;
    logic [READ_LATENCY:0] w_tag_valid;

    // The requester granted last cycle is still holding its old command on
    // the inputs, so it is masked out to avoid a double grant.
    assign w_elig = i_req & ~r_gnt;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .i_elig  (w_elig),
        .i_ptr   (r_ptr),
        .o_idx   (w_win),
        .o_found (w_found)
    );

    assign w_win_onehot = w_found ? (NUM_REQ'(1) << w_win) : '0;
    assign w_tag_in     = '{valid: w_found & ~i_we[w_win], idx: w_win};

    // Command register: issue the winner's fields; addr/din hold when idle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_gnt      <= '0;
            r_mem_en   <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_din  <= '0;
            r_ptr      <= '0;
        end else begin
            r_gnt    <= w_win_onehot;
            r_mem_en <= w_found;
            r_mem_we <= w_found & i_we[w_win];
            if (w_found) begin
                r_mem_addr <= i_addr[w_win*ADDR_WIDTH +: ADDR_WIDTH];
                r_mem_din  <= i_din[w_win*WIDTH +: WIDTH];
                r_ptr      <= next_ptr(w_win, NUM_REQ);
            end
        end
    end

    // Tag pipeline: stage 0 aligns with the command on the memory pins, the
    // last stage aligns with the memory's data on i_mem_dout.
    generate
        for (genvar gi = 0; gi <= READ_LATENCY; gi++) begin : g_tag
            rd_tag_t r_stage;
            if (gi == 0) begin : g_head
                // Capture the tag of the command being issued.
                always_ff @(posedge i_clk or negedge i_rst_n) begin
                    if (!i_rst_n)
                        r_stage <= '0;
                    else
                        r_stage <= w_tag_in;
                end
            end else begin : g_shift
                // Advance the tag one stage per cycle.
                always_ff @(posedge i_clk or negedge i_rst_n) begin
                    if (!i_rst_n)
                        r_stage <= '0;
                    else
                        r_stage <= g_tag[gi-1].r_stage;
                end
            end
            assign w_tag_valid[gi] = r_stage.valid;
        end
    endgenerate

    assign w_tag_out = g_tag[READ_LATENCY].r_stage;

    // Return register: strobe the owning requester and capture the data.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rvalid <= '0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= w_tag_out.valid ? (NUM_REQ'(1) << w_tag_out.idx) : '0;
            if (w_tag_out.valid)
                r_rdata <= i_mem_dout;
        end
    end

    assign o_gnt      = r_gnt;
    assign o_rvalid   = r_rvalid;
    assign o_rdata    = r_rdata;
    assign o_mem_en   = r_mem_en;
    assign o_mem_we   = r_mem_we;
    assign o_mem_addr = r_mem_addr;
    assign o_mem_din  = r_mem_din;
    assign o_busy     = |w_tag_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic, checked
// every cycle against a transaction-level model (queues of pending commands
// and of expected returns with their due cycle).
module tb_mem_port_arbiter;

    parameter int RL = 1;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int AW = 5;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    we = '0;
    logic [N*AW-1:0] addr = '0;
    logic [N*W-1:0]  din = '0;
    logic [N-1:0]    gnt, rvalid;
    logic [W-1:0]    rdata, mem_dout;
    logic            mem_en, mem_we, busy;
    logic [AW-1:0]   mem_addr;
    logic [W-1:0]    mem_din;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .NUM_REQ(N), .WIDTH(W), .ADDR_WIDTH(AW), .READ_LATENCY(RL)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_we(we), .i_addr(addr),
        .i_din(din), .o_gnt(gnt), .o_rvalid(rvalid), .o_rdata(rdata),
        .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_din(mem_din), .i_mem_dout(mem_dout), .o_busy(busy)
    );

    function automatic logic [W-1:0] init_val(input int a);
        return W'(a * 19) ^ 8'h5A;
    endfunction

    // Memory port behaviour: read sampled at the edge, data out RL cycles later.
    logic [W-1:0] mem_arr [0:31];
    logic [W-1:0] dly [0:RL-1];
    bit           mem_ready = 1'b0;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 32; i++) mem_arr[i] <= init_val(i);
            mem_ready <= 1'b1;
        end else if (mem_en) begin
            if (mem_we) mem_arr[mem_addr] <= mem_din;
            else        dly[0] <= mem_arr[mem_addr];
        end
        for (int i = 1; i < RL; i++) dly[i] <= dly[i-1];
    end
    assign mem_dout = dly[RL-1];

    // Transaction-level model state.
    typedef struct { bit wr; logic [AW-1:0] a; logic [W-1:0] d; } txn_t;
    typedef struct { int idx; logic [W-1:0] data; int due; } ret_t;
    typedef struct { int idx; int cyc; logic [W-1:0] data; } log_t;

    txn_t         pend [N][$];
    ret_t         rq [$];
    log_t         glog [$];
    log_t         rlog [$];
    logic [W-1:0] ref_mem [0:31];
    int           ptr_m, cyc;
    logic [N-1:0] gnt_m, rvalid_m;
    logic         en_m, we_m;
    logic [AW-1:0] addr_m;
    logic [W-1:0] din_m, rdata_m;

    int vectors = 0;
    int miscompares = 0;

    function automatic void chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endfunction

    function automatic void model_reset();
        ptr_m = 0; gnt_m = '0; rvalid_m = '0; en_m = 0; we_m = 0;
        addr_m = '0; din_m = '0; rdata_m = '0;
        rq.delete();
        for (int k = 0; k < N; k++) pend[k].delete();
    endfunction

    function automatic void check_all();
        chk("gnt", 32'(gnt), 32'(gnt_m));
        chk("mem_en", 32'(mem_en), 32'(en_m));
        chk("mem_we", 32'(mem_we), 32'(we_m));
        chk("mem_addr", 32'(mem_addr), 32'(addr_m));
        chk("mem_din", 32'(mem_din), 32'(din_m));
        chk("rvalid", 32'(rvalid), 32'(rvalid_m));
        chk("rdata", 32'(rdata), 32'(rdata_m));
        chk("busy", 32'(busy), 32'(rq.size() != 0));
    endfunction

    function automatic txn_t mk(input bit wr, input int a, input int d);
        txn_t t;
        t.wr = wr; t.a = AW'(a); t.d = W'(d);
        return t;
    endfunction

    // One clock: present pending commands, advance model, check after the edge.
    task automatic cycle();
        int win;
        for (int k = 0; k < N; k++) begin
            if (pend[k].size() != 0) begin
                req[k] = 1'b1;
                we[k] = pend[k][0].wr;
                addr[k*AW +: AW] = pend[k][0].a;
                din[k*W +: W] = pend[k][0].d;
            end else begin
                req[k] = 1'b0;
            end
        end
        win = -1;
        for (int j = 0; j < N; j++) begin
            int c;
            c = (ptr_m + j) % N;
            if (win < 0 && req[c] && !gnt_m[c]) win = c;
        end
        if (win >= 0) begin
            gnt_m = N'(1) << win;
            en_m = 1'b1;
            we_m = we[win];
            addr_m = addr[win*AW +: AW];
            din_m = din[win*W +: W];
            ptr_m = (win + 1) % N;
            if (we_m) ref_mem[addr_m] = din_m;
            else rq.push_back('{win, ref_mem[addr_m], cyc + 1 + RL + 1});
        end else begin
            gnt_m = '0; en_m = 1'b0; we_m = 1'b0;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rvalid_m = '0;
        if (rq.size() != 0 && rq[0].due == cyc) begin
            rvalid_m = N'(1) << rq[0].idx;
            rdata_m = rq[0].data;
            void'(rq.pop_front());
        end
        check_all();
        for (int k = 0; k < N; k++) begin
            if (gnt[k]) glog.push_back('{k, cyc, 8'h00});
            if (rvalid[k]) rlog.push_back('{k, cyc, rdata});
            if (gnt_m[k] && pend[k].size() != 0) void'(pend[k].pop_front());
        end
    endtask

    task automatic drain(input int max_cyc);
        int n;
        bit any;
        n = 0;
        any = 1'b1;
        while (any && n < max_cyc) begin
            cycle();
            n++;
            any = (rq.size() != 0);
            for (int k = 0; k < N; k++) if (pend[k].size() != 0) any = 1'b1;
        end
        chk("drain_timeout", 32'(any), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) ref_mem[i] = init_val(i);
        cyc = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all();
        rst_n = 1'b1;

        // Idle: nothing may be issued or returned.
        repeat (20) cycle();

        // Requester 1 writes then reads addr 0.
        glog.delete(); rlog.delete();
        pend[1].push_back(mk(1, 0, 8'hAA));
        pend[1].push_back(mk(0, 0, 0));
        drain(30);
        chk("wr_rd_gnt_count", 32'(glog.size()), 32'd2);
        chk("wr_rd_gnt_gap", 32'(glog[1].cyc - glog[0].cyc), 32'd2);
        chk("wr_rd_ret_idx", 32'(rlog[0].idx), 32'd1);
        chk("wr_rd_ret_data", 32'(rlog[0].data), 32'hAA);
        chk("wr_rd_ret_lat", 32'(rlog[0].cyc - glog[1].cyc), 32'(RL + 1));

        // Requester 3 preloads addrs 2/3, leaving the pointer at 0.
        pend[3].push_back(mk(1, 2, 8'hCC));
        pend[3].push_back(mk(1, 3, 8'hDD));
        drain(30);

        // All four request together: grants 0,1,2,3 on consecutive cycles.
        glog.delete();
        for (int k = 0; k < N; k++) pend[k].push_back(mk(0, k + 4, 0));
        drain(40);
        for (int k = 0; k < N; k++) begin
            chk("all4_order", 32'(glog[k].idx), 32'(k));
            chk("all4_cyc", 32'(glog[k].cyc - glog[0].cyc), 32'(k));
        end

        // Requesters 0 and 3 read 0xCC and 0xDD; returns back to back.
        glog.delete(); rlog.delete();
        pend[0].push_back(mk(0, 2, 0));
        pend[3].push_back(mk(0, 3, 0));
        drain(40);
        chk("pair_ret0_idx", 32'(rlog[0].idx), 32'd0);
        chk("pair_ret0_data", 32'(rlog[0].data), 32'hCC);
        chk("pair_ret1_idx", 32'(rlog[1].idx), 32'd3);
        chk("pair_ret1_data", 32'(rlog[1].data), 32'hDD);
        chk("pair_ret_gap", 32'(rlog[1].cyc - rlog[0].cyc), 32'd1);
        chk("pair_ret_lat", 32'(rlog[0].cyc - glog[0].cyc), 32'(RL + 1));

        // Pointer to 3 via a lone grant to 2, then 0 and 3 contend: 3 first.
        pend[2].push_back(mk(1, 9, 8'h39));
        drain(20);
        glog.delete();
        pend[0].push_back(mk(1, 10, 8'h10));
        pend[3].push_back(mk(1, 11, 8'h11));
        drain(20);
        chk("wrap_first", 32'(glog[0].idx), 32'd3);
        chk("wrap_second", 32'(glog[1].idx), 32'd0);

        // Reset while a read is in flight: nothing may come back.
        rlog.delete();
        pend[2].push_back(mk(0, 2, 0));
        cycle();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (RL + 4) cycle();
        chk("rst_no_return", 32'(rlog.size()), 32'd0);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < N; k++) begin
                if (pend[k].size() == 0 && $urandom_range(0, 2) == 0)
                    pend[k].push_back(mk($urandom_range(0, 1) == 1,
                                         int'($urandom_range(0, 31)),
                                         int'($urandom_range(0, 255))));
            end
            cycle();
        end
        drain(60);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
